sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DeviceId, default 7'h21, meaning 7-bit SCCB slave ID matched against the first phase.
REQ-002 SHALL have parameter TimeoutCycles, default 50_000, meaning CLK cycles with no SIO_C edge before a busy transaction is abandoned.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port CLK, input, 1, system clock.
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_sio_c, input, 1, SCCB clock from the master (asynchronous).
REQ-007 SHALL have port io_sio_d, inout, 1, SCCB data; driven only when the block is responding, otherwise 1'bz.
REQ-008 SHALL have port o_addr, output, 8, latched sub-address.
REQ-009 SHALL have port o_wr_data, output, 8, latched write data.
REQ-010 SHALL have port o_wr_en, output, 1, one-cycle register write strobe.
REQ-011 SHALL have port o_rd_en, output, 1, one-cycle strobe; i_rd_data is sampled in the same cycle.
REQ-012 SHALL have port i_rd_data, input, 8, register value for o_addr.
REQ-013 SHALL have port o_busy, output, 1, high from START to STOP of an addressed transaction.

Function
REQ-014 SHALL pass i_sio_c and io_sio_d through 2-flop synchronizers; all decoding uses the synchronized values.
REQ-015 SHALL detect START as SIO_D falling while SIO_C is high, and STOP as SIO_D rising while SIO_C is high.
REQ-016 SHALL sample data bits MSB-first on the synchronized SIO_C rising edge.
REQ-017 SHALL change any driven SIO_D value only on the cycle after a synchronized SIO_C falling edge.
REQ-018 SHALL implement states IDLE, ID, ID_X, SUBADDR, SUBADDR_X, WDATA, WDATA_X, RDATA, RDATA_NA, IGNORE.
REQ-019 SHALL move IDLE->ID on START.
REQ-020 SHALL, after 8 ID bits, go to ID_X; on the following 9th clock go to SUBADDR if ID[7:1]==DeviceId and R/W=0, to RDATA if R/W=1, and to IGNORE on mismatch.
REQ-021 SHALL latch o_addr after SUBADDR, then go SUBADDR_X->WDATA.
REQ-022 SHALL, after WDATA, go to WDATA_X and pulse o_wr_en for one cycle after the 9th-bit rising edge, with o_wr_data valid in that cycle; it SHALL then go to IGNORE.
REQ-023 SHALL treat STOP after SUBADDR_X as a 2-phase write: o_addr is updated and there is no o_wr_en.
REQ-024 SHALL, on entering RDATA, pulse o_rd_en, capture i_rd_data in that cycle, and drive 8 bits; it SHALL then release SIO_D for RDATA_NA (master NA) and go to IGNORE.
REQ-025 SHALL return every state to IDLE on STOP.
REQ-026 SHALL restart at ID on START in any state (repeated start), with no strobe emitted.
REQ-027 SHALL abort on STOP mid-byte: the partial byte is discarded and no strobe is emitted.
REQ-028 SHALL, on an ID mismatch, never drive SIO_D and never strobe, and keep o_busy low.
REQ-029 SHALL force IDLE when TimeoutCycles elapse with no SIO_C edge while not IDLE, releasing SIO_D.
REQ-030 SHALL keep o_addr unchanged across transactions (no auto-increment).

Reset
REQ-031 SHALL, on RST, set state=IDLE, o_wr_en=0, o_rd_en=0, o_busy=0, o_addr=8'h00, o_wr_data=8'h00, SIO_D released, bit counter=0, timeout counter=0, and synchronizers=1.
REQ-032 SHALL, on RST mid-transaction, release SIO_D in the next cycle and wait for a new START.

Configuration
REQ-033 SHALL provide macro SCCB_RESPONDER_ACK_EN; when defined, the block drives SIO_D low during ID_X, SUBADDR_X and WDATA_X when addressed.
REQ-034 SHALL, without SCCB_RESPONDER_ACK_EN, keep SIO_D released during all 9th bits, as the don't-care bit allows.

Structure
REQ-035 SHALL place the state encoding, the default DeviceId, and the bit-count constant (8) in shared package sccb_pkg, also used by the SCCB master.
REQ-036 SHALL have one sub-module, sccb_line_sync: 2-flop synchronizer plus edge and START/STOP detector for SIO_C/SIO_D.

Verification
REQ-037 SHALL cover: 3-phase write ID 8'h42, sub 8'h12, data 8'h80 -> single o_wr_en, o_addr=8'h12, o_wr_data=8'h80.
REQ-038 SHALL cover: 2-phase write ID 8'h42, sub 8'h0A, then 2-phase read ID 8'h43 with i_rd_data=8'h76 -> o_rd_en once, master reads 8'h76, o_addr=8'h0A.
REQ-039 SHALL cover: ID 8'h60 write -> io_sio_d stays Z, no strobes, o_busy=0.
REQ-040 SHALL cover: STOP after 4 data bits -> no o_wr_en, state IDLE.
REQ-041 SHALL cover: repeated START inside SUBADDR, then full write to 8'h3A/8'h04 -> exactly one o_wr_en with those values.
REQ-042 SHALL cover: SIO_C frozen low mid-RDATA for TimeoutCycles -> SIO_D released, o_busy=0; with SCCB_RESPONDER_ACK_EN, X bits read 0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, default device ID and bits per phase.
// Used by the SCCB responder here and by the SCCB master.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ID        = 4'd1,
    ID_X      = 4'd2,
    SUBADDR   = 4'd3,
    SUBADDR_X = 4'd4,
    WDATA     = 4'd5,
    WDATA_X   = 4'd6,
    RDATA     = 4'd7,
    RDATA_NA  = 4'd8,
    IGNORE    = 4'd9
  } sccb_state_t;

  localparam logic [6:0] SCCB_DEFAULT_ID = 7'h21;
  localparam int         SCCB_BITS       = 8;

endpackage

// File: rtl/sccb_line_sync.sv
// 2-flop synchronizers for SIO_C/SIO_D plus SIO_C edge and START/STOP detection.
// Flops reset to 1 (idle bus) so reset never produces a spurious edge or condition.
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic sio_c,
  input  logic sio_d,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized value.
  logic [2:0] c_q;
  logic [2:0] d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '1;
      d_q <= '1;
    end else begin
      c_q <= {c_q[1:0], sio_c};
      d_q <= {d_q[1:0], sio_d};
    end
  end

  assign sda      = d_q[1];
  assign scl_rise = c_q[1] & ~c_q[2];
  assign scl_fall = ~c_q[1] & c_q[2];
  assign start    = c_q[1] & c_q[2] & d_q[2] & ~d_q[1];
  assign stop     = c_q[1] & c_q[2] & ~d_q[2] & d_q[1];

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave register port: 3-phase write, 2-phase address write and 2-phase read.
// Optional macro SCCB_RESPONDER_ACK_EN drives the 9th (don't-care) bit low when addressed.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DeviceId      = SCCB_DEFAULT_ID,
  parameter int         TimeoutCycles = 50_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_sio_c,
  inout  wire        io_sio_d,
  output logic [7:0] o_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_en,
  output logic       o_rd_en,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic [3:0] o_state
);

  localparam int TW = $clog2(TimeoutCycles + 1);

  sccb_state_t   state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          oe, drv, fall_d;
  logic          sda, scl_rise, scl_fall, start, stop;
  logic          byte_done, id_match, timeout;
  logic          drive_en, drive_val;

  sccb_line_sync u_sync (
    .clk      (CLK),
    .rst      (RST),
    .sio_c    (i_sio_c),
    .sio_d    (io_sio_d),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign io_sio_d  = oe ? drv : 1'bz;
  assign o_state   = state;
  assign byte_done = (bit_cnt == 3'(SCCB_BITS - 1));
  assign id_match  = (shreg[7:1] == DeviceId);
  assign timeout   = (state != IDLE) && !scl_rise && !scl_fall &&
                     (to_cnt == TW'(TimeoutCycles - 1));

  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = IDLE;
    else if (start) state_nxt = ID;
    else if (stop) state_nxt = IDLE;
    else if (scl_rise) begin
      case (state)
        ID:        if (byte_done) state_nxt = ID_X;
        ID_X:      state_nxt = !id_match ? IGNORE : (shreg[0] ? RDATA : SUBADDR);
        SUBADDR:   if (byte_done) state_nxt = SUBADDR_X;
        SUBADDR_X: state_nxt = WDATA;
        WDATA:     if (byte_done) state_nxt = WDATA_X;
        WDATA_X:   state_nxt = IGNORE;
        RDATA:     if (byte_done) state_nxt = RDATA_NA;
        RDATA_NA:  state_nxt = IGNORE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Value presented on SIO_D for the bit slot that follows the current SIO_C fall.
  always_comb begin
    drive_en  = 1'b0;
    drive_val = 1'b1;
    case (state)
      RDATA: begin
        drive_en  = 1'b1;
        drive_val = shreg[7];
      end
`ifdef SCCB_RESPONDER_ACK_EN
      ID_X: begin
        drive_en  = id_match;
        drive_val = 1'b0;
      end
      SUBADDR_X, WDATA_X: begin
        drive_en  = 1'b1;
        drive_val = 1'b0;
      end
`endif
      default: begin
        drive_en  = 1'b0;
        drive_val = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      oe        <= 1'b0;
      drv       <= 1'b1;
      fall_d    <= 1'b0;
      o_addr    <= '0;
      o_wr_data <= '0;
      o_wr_en   <= 1'b0;
      o_rd_en   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      fall_d  <= scl_fall;
      o_wr_en <= 1'b0;
      o_rd_en <= 1'b0;
      if (state == IDLE || scl_rise || scl_fall) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;

      if (start || stop || timeout) begin
        bit_cnt <= '0;
        o_busy  <= 1'b0;
        oe      <= 1'b0;
      end else begin
        if (scl_rise) begin
          if (state == ID || state == SUBADDR || state == WDATA) begin
            shreg   <= {shreg[6:0], sda};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (state == RDATA) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (state == ID_X && id_match) begin
            o_busy  <= 1'b1;
            o_rd_en <= shreg[0];
          end
          if (state == SUBADDR && byte_done) o_addr <= {shreg[6:0], sda};
          if (state == WDATA_X) begin
            o_wr_en   <= 1'b1;
            o_wr_data <= shreg;
          end
        end
        // Read data is loaded in the strobe cycle, well before the first SIO_C fall.
        if (o_rd_en) shreg <= i_rd_data;
        if (fall_d) begin
          oe  <= drive_en;
          drv <= drive_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: bit-banged SCCB master, strobe scoreboard,
// scenario tasks. Honours SCCB_RESPONDER_ACK_EN for the expected 9th-bit value.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q  = 6;
  localparam int TO = 300;
`ifdef SCCB_RESPONDER_ACK_EN
  localparam logic EXP_ACK = 1'b0;
`else
  localparam logic EXP_ACK = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  wire        sio_d;
  logic [7:0] addr, wr_data;
  logic       wr_en, rd_en, busy;
  logic [3:0] state;

  int         vectors = 0;
  int         miscompares = 0;
  int         z_viol = 0;
  logic       watch_z = 1'b0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [15:0] exp_w;
  logic [7:0]  exp_r;

  assign sio_d = sda_low ? 1'b0 : 1'bz;
  pullup (sio_d);

  always #5 clk = ~clk;

  sccb_responder #(.DeviceId(7'h21), .TimeoutCycles(TO)) dut (
    .CLK       (clk),
    .RST       (rst),
    .i_sio_c   (scl),
    .io_sio_d  (sio_d),
    .o_addr    (addr),
    .o_wr_data (wr_data),
    .o_wr_en   (wr_en),
    .o_rd_en   (rd_en),
    .i_rd_data (rd_data),
    .o_busy    (busy),
    .o_state   (state)
  );

  // Scoreboard: every strobe must match the next expected entry.
  always @(negedge clk) begin
    if (wr_en) begin
      vectors++;
      if (exp_wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_strobe unexpected addr=%h data=%h, none required", addr, wr_data);
      end else begin
        exp_w = exp_wr_q.pop_front();
        if ({addr, wr_data} !== exp_w) begin
          miscompares++;
          $display("FAIL wr_strobe got %h/%h required %h/%h", addr, wr_data, exp_w[15:8], exp_w[7:0]);
        end
      end
    end
    if (rd_en) begin
      vectors++;
      if (exp_rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_strobe unexpected addr=%h, none required", addr);
      end else begin
        exp_r = exp_rd_q.pop_front();
        if (addr !== exp_r) begin
          miscompares++;
          $display("FAIL rd_strobe addr got %h required %h", addr, exp_r);
        end
      end
    end
    if (watch_z && ((!sda_low && sio_d !== 1'b1) || busy)) z_viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    sda_low = 1'b0; quarter();
    scl = 1'b1;     quarter();
    sda_low = 1'b1; quarter();
    scl = 1'b0;     quarter();
  endtask

  task automatic m_stop();
    sda_low = 1'b1; quarter();
    scl = 1'b1;     quarter();
    sda_low = 1'b0; quarter();
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_low = !b; quarter();
    scl = 1'b1;   quarter();
    r = sio_d;    quarter();
    scl = 1'b0;   quarter();
  endtask

  task automatic m_byte(input logic [7:0] b, output logic [7:0] r, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      m_bit(b[i], rb);
      r[i] = rb;
    end
    m_bit(1'b1, ack);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 4'(IDLE)) begin miscompares++; $display("FAIL rst_state got %0d required %0d", state, IDLE); end
    vectors++; if ({wr_en, rd_en, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes got %b required 000", {wr_en, rd_en, busy}); end
    vectors++; if ({addr, wr_data} !== 16'h0000) begin miscompares++; $display("FAIL rst_regs got %h required 0000", {addr, wr_data}); end
    vectors++; if (sio_d !== 1'b1) begin miscompares++; $display("FAIL rst_sio_d got %b required 1", sio_d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic       ack, b;
    rd_data = 8'h00;
    exp_rd_q.push_back(8'h00);
    m_start();
    m_byte(8'h43, r, ack);
    m_bit(1'b1, b);
    m_bit(1'b1, b);
    vectors++; if (sio_d !== 1'b0) begin miscompares++; $display("FAIL rmid_drive got %b required 0", sio_d); end
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; @(negedge clk);
    vectors++; if (sio_d !== 1'b1) begin miscompares++; $display("FAIL rmid_release got %b required 1", sio_d); end
    vectors++; if (state !== 4'(IDLE) || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_state got %0d/%b required %0d/0", state, busy, IDLE); end
    scl = 1'b1; quarter();
  endtask

  task automatic test_write3();
    logic [7:0] r;
    logic       a0, a1, a2;
    exp_wr_q.push_back({8'h12, 8'h80});
    m_start();
    m_byte(8'h42, r, a0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL w3_busy got %b required 1", busy); end
    m_byte(8'h12, r, a1);
    m_byte(8'h80, r, a2);
    m_stop();
    quarter();
    vectors++; if ({a0, a1, a2} !== {3{EXP_ACK}}) begin miscompares++; $display("FAIL w3_ack got %b required %b", {a0, a1, a2}, {3{EXP_ACK}}); end
    vectors++; if ({addr, wr_data} !== 16'h1280) begin miscompares++; $display("FAIL w3_regs got %h required 1280", {addr, wr_data}); end
    vectors++; if (state !== 4'(IDLE) || busy !== 1'b0) begin miscompares++; $display("FAIL w3_idle got %0d/%b required %0d/0", state, busy, IDLE); end
  endtask

  task automatic test_read();
    logic [7:0] r;
    logic       a0, a1, na;
    m_start();
    m_byte(8'h42, r, a0);
    m_byte(8'h0A, r, a1);
    m_stop();
    quarter();
    vectors++; if (addr !== 8'h0A) begin miscompares++; $display("FAIL rd_addr2 got %h required 0a", addr); end
    rd_data = 8'h76;
    exp_rd_q.push_back(8'h0A);
    m_start();
    m_byte(8'h43, r, a0);
    m_byte(8'hFF, r, na);
    m_stop();
    quarter();
    vectors++; if (r !== 8'h76) begin miscompares++; $display("FAIL rd_data got %h required 76", r); end
    vectors++; if (na !== 1'b1 || a0 !== EXP_ACK) begin miscompares++; $display("FAIL rd_ack got %b/%b required %b/1", a0, na, EXP_ACK); end
    vectors++; if (addr !== 8'h0A) begin miscompares++; $display("FAIL rd_addr got %h required 0a", addr); end
  endtask

  task automatic test_mismatch();
    logic [7:0] r;
    logic       a0, a1, a2;
    z_viol = 0;
    watch_z = 1'b1;
    m_start();
    m_byte(8'h60, r, a0);
    m_byte(8'h12, r, a1);
    m_byte(8'h34, r, a2);
    m_stop();
    quarter();
    watch_z = 1'b0;
    vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL mm_ack got %b required 111", {a0, a1, a2}); end
    vectors++; if (z_viol !== 0) begin miscompares++; $display("FAIL mm_drive_busy got %0d violations required 0", z_viol); end
    vectors++; if (addr !== 8'h0A) begin miscompares++; $display("FAIL mm_addr got %h required 0a", addr); end
  endtask

  task automatic test_stop_mid();
    logic [7:0] r;
    logic       ack, b;
    m_start();
    m_byte(8'h42, r, ack);
    m_byte(8'h12, r, ack);
    for (int i = 0; i < 4; i++) m_bit(1'b1, b);
    m_stop();
    quarter();
    vectors++; if (state !== 4'(IDLE)) begin miscompares++; $display("FAIL smid_state got %0d required %0d", state, IDLE); end
    vectors++; if ({addr, wr_data} !== 16'h1280) begin miscompares++; $display("FAIL smid_regs got %h required 1280", {addr, wr_data}); end
  endtask

  task automatic test_rep_start();
    logic [7:0] r;
    logic       ack, b;
    exp_wr_q.push_back({8'h3A, 8'h04});
    m_start();
    m_byte(8'h42, r, ack);
    for (int i = 0; i < 4; i++) m_bit(1'b1, b);
    m_start();
    m_byte(8'h42, r, ack);
    m_byte(8'h3A, r, ack);
    m_byte(8'h04, r, ack);
    m_stop();
    quarter();
    vectors++; if ({addr, wr_data} !== 16'h3A04) begin miscompares++; $display("FAIL rs_regs got %h required 3a04", {addr, wr_data}); end
  endtask

  task automatic test_timeout();
    logic [7:0] r;
    logic [2:0] bits;
    logic       ack, b;
    rd_data = 8'h0F;
    exp_rd_q.push_back(8'h3A);
    m_start();
    m_byte(8'h43, r, ack);
    for (int i = 2; i >= 0; i--) begin
      m_bit(1'b1, b);
      bits[i] = b;
    end
    quarter();
    vectors++; if (bits !== 3'b000 || sio_d !== 1'b0) begin miscompares++; $display("FAIL to_bits got %b/%b required 000/0", bits, sio_d); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_pre got %b required 1", busy); end
    repeat (TO + 10) @(negedge clk);
    vectors++; if (sio_d !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL to_release got %b/%b required 1/0", sio_d, busy); end
    vectors++; if (state !== 4'(IDLE)) begin miscompares++; $display("FAIL to_state got %0d required %0d", state, IDLE); end
    scl = 1'b1; quarter();
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, a, d;
    logic       ack;
    for (int n = 0; n < 3; n++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      exp_wr_q.push_back({a, d});
      m_start();
      m_byte(8'h42, r, ack);
      m_byte(a, r, ack);
      m_byte(d, r, ack);
      m_stop();
      rd_data = 8'($urandom_range(0, 255));
      exp_rd_q.push_back(a);
      m_start();
      m_byte(8'h43, r, ack);
      m_byte(8'hFF, r, ack);
      m_stop();
      quarter();
      vectors++; if (r !== rd_data) begin miscompares++; $display("FAIL b2b_read[%0d] got %h required %h", n, r, rd_data); end
      vectors++; if ({addr, wr_data} !== {a, d}) begin miscompares++; $display("FAIL b2b_regs[%0d] got %h required %h", n, {addr, wr_data}, {a, d}); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write3();
    test_read();
    test_mismatch();
    test_stop_mid();
    test_rep_start();
    test_timeout();
    test_back_to_back();
    repeat (4) @(negedge clk);
    vectors++; if (exp_wr_q.size() !== 0) begin miscompares++; $display("FAIL wr_pending got %0d required 0", exp_wr_q.size()); end
    vectors++; if (exp_rd_q.size() !== 0) begin miscompares++; $display("FAIL rd_pending got %0d required 0", exp_rd_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
